// File: rtl/encoded_stream_packer_pkg.sv
// Shared constants, state encoding and helpers for the JPEG-LS output bit packer.
package encoded_stream_packer_pkg;

    localparam int dataOut_length      = 64;
    localparam int encodedlength_width = 7;
    localparam int BUF_W               = 80;

    localparam int DW    = dataOut_length;
    localparam int LW    = encodedlength_width;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int SUM_W = CNT_W + 1;

    localparam logic [7:0] STUFF_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_PACK  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } pack_state_e;

    // Over-long codewords are truncated to the bus width.
    function automatic logic [LW-1:0] clip_len(input logic [LW-1:0] len);
        return (len > LW'(DW)) ? LW'(DW) : len;
    endfunction

endpackage

// File: rtl/packer_bit_accumulator.sv
// MSB-first bit accumulator: removes the oldest bits and appends new codeword bits in one edge.
module packer_bit_accumulator
    import encoded_stream_packer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             append_en_i,
    input  logic [DW-1:0]    append_data_i,
    input  logic [LW-1:0]    append_len_i,
    input  logic             remove_en_i,
    input  logic [CNT_W-1:0] remove_len_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o,
    output logic [7:0]       head_next_o
);

    logic [BUF_W-1:0] buf_q, buf_d, drained, aligned;
    logic [CNT_W-1:0] count_q, count_d, drained_count;
    logic [DW-1:0]    len_mask;

    // Keep only the top append_len_i bits so unused bits never pollute the buffer.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_len_mask
            assign len_mask[gi] = (gi + int'(append_len_i)) >= DW;
        end
    endgenerate

    always_comb begin
        drained       = remove_en_i ? (buf_q << remove_len_i) : buf_q;
        drained_count = remove_en_i ? (count_q - remove_len_i) : count_q;
        aligned       = {append_data_i & len_mask, {(BUF_W-DW){1'b0}}} >> drained_count;
        buf_d         = append_en_i ? (drained | aligned) : drained;
        count_d       = append_en_i ? (drained_count + CNT_W'(append_len_i)) : drained_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign head_next_o  = buf_d[BUF_W-1 -: 8];

endmodule

// File: rtl/encoded_stream_packer.sv
// Arbitrates three codeword sources into a byte stream with 0xFF bit stuffing and end-of-scan flush.
module encoded_stream_packer
    import encoded_stream_packer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    reg_data,
    input  logic [LW-1:0]    reg_len,
    input  logic             reg_valid,
    output logic             reg_ready,
    input  logic [DW-1:0]    run_data,
    input  logic [LW-1:0]    run_len,
    input  logic             run_valid,
    output logic             run_ready,
    input  logic [DW-1:0]    eor_data,
    input  logic [LW-1:0]    eor_len,
    input  logic             eor_valid,
    output logic             eor_ready,
    input  logic             flush_req,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             flush_done,
    output logic             len_err,
    output logic [CNT_W-1:0] bit_count
);

    pack_state_e      state_q, state_d;
    logic             flush_q, flush_d;
    logic             stuff_q, stuff_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             len_err_q, len_err_d;

    logic             gnt_run, gnt_eor, gnt_reg, any_valid;
    logic             pack_open, fits, accept, emit;
    logic [DW-1:0]    sel_data;
    logic [LW-1:0]    sel_len, sel_len_eff;
    logic [CNT_W-1:0] count_q, count_d, need_q, need_d, remove_len;
    logic [7:0]       head_d;

    // Fixed priority run > eor > reg.
    always_comb begin
        gnt_run   = run_valid;
        gnt_eor   = eor_valid && !run_valid;
        gnt_reg   = reg_valid && !run_valid && !eor_valid;
        any_valid = run_valid || eor_valid || reg_valid;
        sel_data  = reg_data;
        sel_len   = reg_len;
        if (gnt_run) begin
            sel_data = run_data;
            sel_len  = run_len;
        end else if (gnt_eor) begin
            sel_data = eor_data;
            sel_len  = eor_len;
        end
    end

    assign sel_len_eff = clip_len(sel_len);
    assign fits        = (SUM_W'(count_q) + SUM_W'(sel_len_eff)) <= SUM_W'(BUF_W);
    assign accept      = any_valid && pack_open && fits;
    assign run_ready   = gnt_run && pack_open && fits;
    assign eor_ready   = gnt_eor && pack_open && fits;
    assign reg_ready   = gnt_reg && pack_open && fits;

    assign need_q     = stuff_q ? CNT_W'(7) : CNT_W'(8);
    assign emit       = byte_valid_q && byte_ready;
    // A padded final byte during flush takes whatever is left.
    assign remove_len = (count_q >= need_q) ? need_q : count_q;

    packer_bit_accumulator u_acc (
        .clk           (clk),
        .rst_n         (rst_n),
        .append_en_i   (accept),
        .append_data_i (sel_data),
        .append_len_i  (sel_len_eff),
        .remove_en_i   (emit),
        .remove_len_i  (remove_len),
        .count_o       (count_q),
        .count_next_o  (count_d),
        .head_next_o   (head_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PACK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PACK:  if ((flush_q || flush_req) && !any_valid) state_d = ST_FLUSH;
            ST_FLUSH: if (count_q == '0 && !byte_valid_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_PACK;
            default:  state_d = ST_PACK;
        endcase
    end

    always_comb begin
        pack_open  = (state_q == ST_PACK);
        flush_done = (state_q == ST_DONE);
    end

    // Output byte is precomputed from the post-edge accumulator so it is stable under backpressure.
    always_comb begin
        flush_d = 1'b0;
        if (state_q == ST_PACK && state_d == ST_PACK) flush_d = flush_q || flush_req;
        stuff_d = stuff_q;
        if (state_q == ST_DONE) stuff_d = 1'b0;
        else if (emit)          stuff_d = (byte_out_q == STUFF_BYTE);
        need_d       = stuff_d ? CNT_W'(7) : CNT_W'(8);
        byte_valid_d = (count_d >= need_d) || (state_d == ST_FLUSH && count_d != '0);
        byte_out_d   = '0;
        if (byte_valid_d) byte_out_d = stuff_d ? {1'b0, head_d[7:1]} : head_d;
        len_err_d = len_err_q || (accept && sel_len > LW'(DW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q      <= 1'b0;
            stuff_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_out_q   <= '0;
            len_err_q    <= 1'b0;
        end else begin
            flush_q      <= flush_d;
            stuff_q      <= stuff_d;
            byte_valid_q <= byte_valid_d;
            byte_out_q   <= byte_out_d;
            len_err_q    <= len_err_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign len_err    = len_err_q;
    assign bit_count  = count_q;

endmodule

// File: tb/tb_encoded_stream_packer.sv
// Randomized and directed bench for encoded_stream_packer against a bit-queue stream model.
module tb_encoded_stream_packer;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] reg_data = '0, run_data = '0, eor_data = '0;
    logic [6:0]  reg_len = '0, run_len = '0, eor_len = '0;
    logic        reg_valid = 1'b0, run_valid = 1'b0, eor_valid = 1'b0;
    logic        flush_req = 1'b0, byte_ready = 1'b0;
    logic        reg_ready, run_ready, eor_ready;
    logic [7:0]  byte_out;
    logic        byte_valid, flush_done, len_err;
    logic [6:0]  bit_count;

    int      checks = 0, failures = 0, done_cnt = 0, nbytes = 0;
    byte_q_t dut_bytes, model_bytes, exp_q;

    // Model: pending stream bits in order, plus protocol state (0 pack, 1 flush, 2 done).
    bit         m_q[$];
    int         m_state = 0;
    bit         m_flush = 0, m_stuff = 0, m_valid = 0, m_err = 0;
    logic [7:0] m_byte = '0;

    encoded_stream_packer dut (
        .clk(clk), .rst_n(rst_n),
        .reg_data(reg_data), .reg_len(reg_len), .reg_valid(reg_valid), .reg_ready(reg_ready),
        .run_data(run_data), .run_len(run_len), .run_valid(run_valid), .run_ready(run_ready),
        .eor_data(eor_data), .eor_len(eor_len), .eor_valid(eor_valid), .eor_ready(eor_ready),
        .flush_req(flush_req), .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .flush_done(flush_done), .len_err(len_err), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int grant_idx();
        if (run_valid) return 0;
        if (eor_valid) return 1;
        if (reg_valid) return 2;
        return -1;
    endfunction

    function automatic int raw_len(input int g);
        return (g == 0) ? int'(run_len) : (g == 1) ? int'(eor_len) : int'(reg_len);
    endfunction

    function automatic int eff_len(input int g);
        return (raw_len(g) > 64) ? 64 : raw_len(g);
    endfunction

    function automatic logic [63:0] gdata(input int g);
        return (g == 0) ? run_data : (g == 1) ? eor_data : reg_data;
    endfunction

    function automatic bit model_fit(input int g);
        return g >= 0 && m_state == 0 && (m_q.size() + eff_len(g) <= 80);
    endfunction

    task automatic model_view();
        int need;
        need    = m_stuff ? 7 : 8;
        m_valid = (m_q.size() >= need) || (m_state == 1 && m_q.size() > 0);
        m_byte  = '0;
        if (m_valid)
            for (int i = 0; i < need; i++)
                m_byte[need-1-i] = (i < m_q.size()) ? m_q[i] : 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_state = 0; m_flush = 0; m_stuff = 0; m_valid = 0; m_err = 0; m_byte = '0;
        end else begin
            int g, sz0, need, k;
            bit v0, acc;
            logic [63:0] d;
            g   = grant_idx();
            acc = model_fit(g);
            sz0 = m_q.size();
            v0  = m_valid;
            need = m_stuff ? 7 : 8;
            if (m_valid && byte_ready) begin
                k = (sz0 < need) ? sz0 : need;
                repeat (k) void'(m_q.pop_front());
                m_stuff = (m_byte == 8'hFF);
                model_bytes.push_back(m_byte);
            end
            if (acc) begin
                d = gdata(g);
                for (int i = 0; i < eff_len(g); i++) m_q.push_back(d[63-i]);
                if (raw_len(g) > 64) m_err = 1;
            end
            case (m_state)
                0: if (m_flush || flush_req) begin
                       if (g < 0) begin m_state = 1; m_flush = 0; end
                       else m_flush = 1;
                   end
                1: if (sz0 == 0 && !v0) m_state = 2;
                default: begin m_state = 0; m_stuff = 0; end
            endcase
            model_view();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int g;
            g = grant_idx();
            chk("bit_count", bit_count, m_q.size());
            chk("byte_valid", byte_valid, m_valid);
            if (m_valid) chk("byte_out", byte_out, m_byte);
            chk("run_ready", run_ready, model_fit(g) && g == 0);
            chk("eor_ready", eor_ready, model_fit(g) && g == 1);
            chk("reg_ready", reg_ready, model_fit(g) && g == 2);
            chk("flush_done", flush_done, m_state == 2);
            chk("len_err", len_err, m_err);
            if (flush_done) done_cnt++;
        end
    end

    always @(posedge clk) begin
        if (rst_n && byte_valid && byte_ready) begin
            dut_bytes.push_back(byte_out);
            $display("byte %0d: 0x%02h bit_count=%0d", nbytes, byte_out, bit_count);
            nbytes++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_valid = 0; run_valid = 0; eor_valid = 0; flush_req = 0;
    endtask

    task automatic clear();
        dut_bytes.delete(); model_bytes.delete(); done_cnt = 0;
    endtask

    task automatic check_bytes(input string name);
        chk({name, "_count"}, dut_bytes.size(), exp_q.size());
        chk({name, "_model_count"}, model_bytes.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(name, (i < dut_bytes.size()) ? 64'(dut_bytes[i]) : 64'hDEAD, exp_q[i]);
            chk({name, "_model"}, (i < model_bytes.size()) ? 64'(model_bytes[i]) : 64'hDEAD, exp_q[i]);
        end
    endtask

    task automatic send_reg(input logic [63:0] d, input logic [6:0] l);
        reg_valid = 1; reg_data = d; reg_len = l;
    endtask

    initial begin
        int n;
        #2;
        chk("rst_bit_count", bit_count, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_out", byte_out, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_reg_ready", reg_ready, 0);
        #10 rst_n = 1;
        step(1);

        // Two back-to-back regular bytes.
        clear(); byte_ready = 1;
        send_reg(64'hA500_0000_0000_0000, 8); step(1);
        send_reg(64'h3C00_0000_0000_0000, 8); step(1);
        idle(); step(4);
        exp_q = {8'hA5, 8'h3C}; check_bytes("seq_a5_3c");
        chk("seq_bit_count", bit_count, 0);

        // Priority and stuffing: FF then 7-bit byte with leading zero.
        clear();
        run_valid = 1; run_data = 64'hF000_0000_0000_0000; run_len = 4;
        eor_valid = 1; eor_data = 64'hFF00_0000_0000_0000; eor_len = 12;
        send_reg(64'hA500_0000_0000_0000, 8);
        #1;
        chk("grant_run", run_ready, 1);
        chk("grant_eor_blocked", eor_ready, 0);
        chk("grant_reg_blocked", reg_ready, 0);
        step(1); run_valid = 0; #1;
        chk("grant_eor", eor_ready, 1);
        chk("grant_reg_blocked2", reg_ready, 0);
        step(1); eor_valid = 0;
        step(1); idle(); flush_req = 1;
        step(1); flush_req = 0; step(8);
        exp_q = {8'hFF, 8'h78, 8'h52, 8'h80}; check_bytes("prio_stuff");
        chk("prio_done_pulses", done_cnt, 1);

        // Full ones stream: FF, stuffed 7F, padded tail.
        clear();
        run_valid = 1; run_data = 64'hFF00_0000_0000_0000; run_len = 8;
        send_reg(64'hFF00_0000_0000_0000, 8);
        step(1); run_valid = 0;
        step(1); idle(); flush_req = 1;
        step(1); flush_req = 0; step(8);
        exp_q = {8'hFF, 8'h7F, 8'h80}; check_bytes("ones_stuff");

        // Partial byte flush and fresh start afterwards.
        clear();
        send_reg(64'hA000_0000_0000_0000, 3); step(1);
        idle(); flush_req = 1; step(1); flush_req = 0; step(6);
        chk("flush_done_once", done_cnt, 1);
        send_reg(64'hA500_0000_0000_0000, 8); step(1); idle(); step(4);
        exp_q = {8'hA0, 8'hA5}; check_bytes("flush_pad");

        // Backpressure fill and drain.
        clear(); byte_ready = 0;
        send_reg(64'h0123_4567_89AB_CDEF, 64); step(1);
        chk("bp_count", bit_count, 64);
        chk("bp_ready_low", reg_ready, 0);
        step(3);
        chk("bp_ready_stays_low", reg_ready, 0);
        chk("bp_count_hold", bit_count, 64);
        idle(); byte_ready = 1; step(12);
        exp_q = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF}; check_bytes("bp_drain");
        chk("bp_empty", bit_count, 0);

        // Over-long and zero-length codewords.
        clear(); byte_ready = 0;
        send_reg(64'h1122_3344_5566_7788, 70); step(1);
        send_reg(64'hFFFF_FFFF_FFFF_FFFF, 0); #1;
        chk("len_err_set", len_err, 1);
        chk("len70_count", bit_count, 64);
        chk("len0_ready", reg_ready, 1);
        step(1); idle(); #1;
        chk("len0_count", bit_count, 64);
        byte_ready = 1; step(12);
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}; check_bytes("len_clip");
        chk("len_err_sticky", len_err, 1);

        // Asynchronous reset with 37 bits held.
        clear(); byte_ready = 0;
        send_reg(64'hFFFF_FFFF_F800_0000, 37); step(1); idle();
        chk("pre_rst_count", bit_count, 37);
        #3 rst_n = 0; #1;
        chk("arst_bit_count", bit_count, 0);
        chk("arst_byte_valid", byte_valid, 0);
        chk("arst_byte_out", byte_out, 0);
        chk("arst_len_err", len_err, 0);
        chk("arst_flush_done", flush_done, 0);
        @(negedge clk); rst_n = 1; step(1);
        clear(); byte_ready = 1;
        send_reg(64'hA500_0000_0000_0000, 8); step(1); idle(); step(4);
        exp_q = {8'hA5}; check_bytes("post_rst");

        // Randomized traffic checked cycle by cycle against the model.
        clear();
        for (int c = 0; c < 3000; c++) begin
            int r;
            run_valid = ($urandom_range(0, 9) < 3);
            eor_valid = ($urandom_range(0, 9) < 3);
            reg_valid = ($urandom_range(0, 9) < 5);
            run_data = {$urandom, $urandom}; eor_data = {$urandom, $urandom}; reg_data = {$urandom, $urandom};
            r = $urandom_range(0, 19);
            run_len = (r == 0) ? 7'($urandom_range(65, 127)) : (r == 1) ? 7'd0 : (r == 2) ? 7'd64 : 7'($urandom_range(1, 40));
            eor_len = 7'($urandom_range(0, 30));
            r = $urandom_range(0, 19);
            reg_len = (r == 0) ? 7'($urandom_range(65, 127)) : (r == 1) ? 7'd0 : (r == 2) ? 7'd64 : 7'($urandom_range(1, 24));
            byte_ready = ($urandom_range(0, 9) < 7);
            flush_req  = ($urandom_range(0, 99) < 3);
            step(1);
        end
        idle(); byte_ready = 1; flush_req = 1; step(1); flush_req = 0;
        n = 0;
        while (!flush_done && n < 300) begin step(1); n++; end
        chk("final_flush_reached", n < 300, 1);
        step(2);
        chk("final_empty", bit_count, 0);
        chk("random_byte_total", dut_bytes.size(), model_bytes.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
